ws2812b_rx: RTL and testbench
=============================

// Module: ws2812b_rx
// PURPOSE
//  Downstream receiver/decoder for the WS2812B single-wire protocol; samples a serial
//  line (loopback of the ws2812b transmitter output or an external chain tap).
//  Measures pulse widths, rebuilds 24-bit GRB pixel words MSB-first, detects frame
//  resets and queues pixels in a small FIFO. Memory-mapped peripheral on the shared
//  8-bit-address / 32-bit-data register bus.
// PARAMETERS
//  FIFO_DEPTH   8       pixel FIFO entries; power of 2, 2..16
//  (timing)     -       derived from `CLK_FREQ, ceil(ns/CLK_PERIOD_NS); at 50 MHz:
//                       T_MIN=100ns(5) T_THRESH=625ns(32) T_HMAX=5us(250) T_RSTDET=25us(1250)
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous active-low reset
//  address     in   8   register byte address
//  write_data  in   32  bus write data
//  read_data   out  32  bus read data, combinational from address
//  we          in   1   write strobe, one cycle
//  re          in   1   read strobe, one cycle
//  ws_in       in   1   serial WS2812B line, asynchronous to clk
// BEHAVIOUR
//  Regs: 0x00 DATA (RO)   {8'b0,head pixel}; 0 when empty. re@0x00 && !empty pops at edge.
//        0x04 STATUS      [0]empty [1]full [2]overflow* [3]frame_done* [4]bit_err* [11:8]count
//                         (*sticky, write-1-to-clear); other bits 0.
//        0x08 CTRL        [0]enable (RW, reset 0); [1] write-1 flushes FIFO (reads 0).
//        0x0C FRAME_PIX   [15:0] pixel count of last completed frame (RO). Others read 0.
//  Reset: read_data follows regs (all 0 except STATUS=0x1); FIFO empty, state S_SYNC.
//  ws_in passes a 2-FF synchroniser; edges detected on synced value (latency 2-3 clk).
//  cnt: 16-bit, saturating, cleared on every state entry.
//  FSM:
//   S_SYNC : wait line low >= T_RSTDET (any rising edge restarts cnt) -> S_IDLE.
//   S_IDLE : rising edge -> S_HIGH.
//   S_HIGH : falling edge: cnt<T_MIN -> bit_err, S_SYNC; else bit=(cnt>=T_THRESH),
//            shift into shreg, bitcnt++ -> S_LOW. cnt reaches T_HMAX -> bit_err, S_SYNC.
//   S_LOW  : rising edge -> S_HIGH. cnt reaches T_RSTDET -> end of frame -> S_IDLE.
//  Pixel: bitcnt==24 -> push shreg (same cycle as 24th falling edge), bitcnt=0,
//         frame_pix++ (saturate 0xFFFF). Full and no pop -> drop, set overflow.
//  End of frame: bitcnt!=0 -> partial pixel discarded, set bit_err. frame_pix!=0 ->
//         FRAME_PIX<=frame_pix, set frame_done. frame_pix, bitcnt cleared.
//  enable=0: FSM held in S_SYNC, shreg/bitcnt/frame_pix cleared; FIFO, sticky, regs kept.
//  Simultaneous: push+pop on full -> both occur, no overflow. push+pop on empty -> push
//         only. flush beats push/pop same cycle. Sticky set beats W1C same cycle.
//  FIFO count wraps never: count range 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
// TESTING (50 MHz, ws2812b transmitter looped back to ws_in)
//  1 TX led0=0x123456, rest 0, enable=1 -> after first TX reset gap, DATA pops 0x123456
//    then 7x 0x000000; FRAME_PIX=8; frame_done=1; W1C 0x08 -> frame_done=0.
//  2 No pops for 2 frames (16 px) -> full=1, overflow=1, count=8; pops give frame 1 px.
//  3 Hand-driven: 12 bits then 30us low -> bit_err=1, FIFO unchanged, FRAME_PIX unchanged.
//  4 High pulses 60ns -> bit_err; high 6us -> bit_err; both return to S_SYNC, then
//    next valid frame decoded correctly after 25us low.
//  5 Full FIFO, pop on same cycle as 24th bit -> count stays 8, overflow stays 0;
//    CTRL write 0x3 during push -> count=0.
//  6 Assert rst_n low mid-pixel -> all regs reset, STATUS=0x1; enable=0 mid-frame ->
//    partial pixel lost, no bit_err; re-enable waits for reset gap.

Source files
------------

// File: rtl/ws2812b_rx.sv
// WS2812B line receiver: synchronises the serial line, classifies pulse widths into bits,
// assembles 24-bit GRB pixels, tracks frames and queues pixels behind a register bus.
`ifndef CLK_FREQ
`define CLK_FREQ 50000000
`endif

module ws2812b_rx #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    input  logic        we,
    input  logic        re,
    input  logic        ws_in
);

    localparam int unsigned ClkPeriodNs = 1000000000 / `CLK_FREQ;
    localparam int unsigned TMinCyc     = (100 + ClkPeriodNs - 1) / ClkPeriodNs;
    localparam int unsigned TThreshCyc  = (625 + ClkPeriodNs - 1) / ClkPeriodNs;
    localparam int unsigned THMaxCyc    = (5000 + ClkPeriodNs - 1) / ClkPeriodNs;
    localparam int unsigned TRstDetCyc  = (25000 + ClkPeriodNs - 1) / ClkPeriodNs;

    localparam logic [15:0] TMin     = 16'(TMinCyc);
    localparam logic [15:0] TThresh  = 16'(TThreshCyc);
    localparam logic [15:0] THMax    = 16'(THMaxCyc);
    localparam logic [15:0] TRstDet  = 16'(TRstDetCyc);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    localparam logic [7:0] AddrData     = 8'h00;
    localparam logic [7:0] AddrStatus   = 8'h04;
    localparam logic [7:0] AddrCtrl     = 8'h08;
    localparam logic [7:0] AddrFramePix = 8'h0C;

    typedef enum logic [1:0] {StSync, StIdle, StHigh, StLow} state_e;

    // ------------------------------------------------------------------
    // Line synchroniser and edge detection
    // ------------------------------------------------------------------
    logic ws_meta_q, ws_sync_q, ws_prev_q;
    logic rise_edge, fall_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws_meta_q <= 1'b0;
            ws_sync_q <= 1'b0;
            ws_prev_q <= 1'b0;
        end else begin
            ws_meta_q <= ws_in;
            ws_sync_q <= ws_meta_q;
            ws_prev_q <= ws_sync_q;
        end
    end

    assign rise_edge = ws_sync_q & ~ws_prev_q;
    assign fall_edge = ~ws_sync_q & ws_prev_q;

    // ------------------------------------------------------------------
    // Register bus decode
    // ------------------------------------------------------------------
    logic wr_status, wr_ctrl, pop_req, flush;
    logic enable_q, enable_d;

    assign wr_status = we && (address == AddrStatus);
    assign wr_ctrl   = we && (address == AddrCtrl);
    assign flush     = wr_ctrl && write_data[1];

    logic unused_wdata;
    assign unused_wdata = ^write_data[31:5];

    // ------------------------------------------------------------------
    // Decoder FSM
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [23:0] shreg_q, shreg_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic [15:0] frame_pix_q, frame_pix_d;

    logic        bit_valid, bit_val, hi_err, eof, px_push;
    logic [23:0] px_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StSync;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable_q) begin
            state_d = StSync;
        end else begin
            unique case (state_q)
                StSync: if (!ws_sync_q && cnt_q >= TRstDet) state_d = StIdle;
                StIdle: if (rise_edge) state_d = StHigh;
                StHigh: begin
                    if (fall_edge) begin
                        state_d = (cnt_q < TMin) ? StSync : StLow;
                    end else if (cnt_q >= THMax) begin
                        state_d = StSync;
                    end
                end
                StLow: begin
                    if (rise_edge) begin
                        state_d = StHigh;
                    end else if (cnt_q >= TRstDet) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StSync;
            endcase
        end
    end

    always_comb begin
        bit_valid = 1'b0;
        hi_err    = 1'b0;
        eof       = 1'b0;
        bit_val   = (cnt_q >= TThresh);
        if (enable_q) begin
            unique case (state_q)
                StHigh: begin
                    if (fall_edge) begin
                        bit_valid = (cnt_q >= TMin);
                        hi_err    = (cnt_q < TMin);
                    end else begin
                        hi_err    = (cnt_q >= THMax);
                    end
                end
                StLow:   eof = !rise_edge && (cnt_q >= TRstDet);
                default: ;
            endcase
        end
        px_push = bit_valid && (bitcnt_q == 5'd23);
        px_data = {shreg_q[22:0], bit_val};
    end

    // Counter restarts on every state change; in StSync the line must stay low throughout.
    always_comb begin
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        frame_pix_d = frame_pix_q;

        if (!enable_q || state_d != state_q || (state_q == StSync && ws_sync_q)) begin
            cnt_d = '0;
        end else if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end

        if (!enable_q || state_q == StSync) begin
            shreg_d     = '0;
            bitcnt_d    = '0;
            frame_pix_d = '0;
        end else if (bit_valid) begin
            shreg_d = px_data;
            if (px_push) begin
                bitcnt_d = '0;
                if (frame_pix_q != 16'hFFFF) frame_pix_d = frame_pix_q + 16'd1;
            end else begin
                bitcnt_d = bitcnt_q + 5'd1;
            end
        end else if (eof) begin
            shreg_d     = '0;
            bitcnt_d    = '0;
            frame_pix_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            frame_pix_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            frame_pix_q <= frame_pix_d;
        end
    end

    // ------------------------------------------------------------------
    // Pixel FIFO
    // ------------------------------------------------------------------
    logic [23:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            empty, full, do_push, do_pop, overflow_set;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(FIFO_DEPTH));
    assign pop_req = re && (address == AddrData) && !empty;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        do_pop       = 1'b0;
        do_push      = 1'b0;
        overflow_set = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            do_pop       = pop_req;
            do_push      = px_push && (!full || pop_req);
            overflow_set = px_push && full && !pop_req;
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= px_data;
    end

    // ------------------------------------------------------------------
    // Status / control registers
    // ------------------------------------------------------------------
    logic        overflow_q, overflow_d;
    logic        frame_done_q, frame_done_d;
    logic        bit_err_q, bit_err_d;
    logic [15:0] frame_pix_reg_q, frame_pix_reg_d;
    logic        set_bit_err, set_frame_done;

    assign set_bit_err    = hi_err || (eof && bitcnt_q != 5'd0);
    assign set_frame_done = eof && (frame_pix_q != 16'd0);

    // Sticky set takes priority over a write-1-to-clear in the same cycle.
    always_comb begin
        enable_d        = wr_ctrl ? write_data[0] : enable_q;
        overflow_d      = overflow_q;
        frame_done_d    = frame_done_q;
        bit_err_d       = bit_err_q;
        frame_pix_reg_d = set_frame_done ? frame_pix_q : frame_pix_reg_q;
        if (wr_status) begin
            if (write_data[2]) overflow_d   = 1'b0;
            if (write_data[3]) frame_done_d = 1'b0;
            if (write_data[4]) bit_err_d    = 1'b0;
        end
        if (overflow_set)   overflow_d   = 1'b1;
        if (set_frame_done) frame_done_d = 1'b1;
        if (set_bit_err)    bit_err_d    = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q        <= 1'b0;
            overflow_q      <= 1'b0;
            frame_done_q    <= 1'b0;
            bit_err_q       <= 1'b0;
            frame_pix_reg_q <= '0;
        end else begin
            enable_q        <= enable_d;
            overflow_q      <= overflow_d;
            frame_done_q    <= frame_done_d;
            bit_err_q       <= bit_err_d;
            frame_pix_reg_q <= frame_pix_reg_d;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [4:0]  count_ext;
    logic        unused_count;
    logic [31:0] status;

    assign count_ext    = 5'(count_q);
    assign unused_count = count_ext[4];
    assign status       = {20'd0, count_ext[3:0], 3'd0, bit_err_q, frame_done_q, overflow_q,
                           full, empty};

    always_comb begin
        read_data = '0;
        case (address)
            AddrData:     read_data = empty ? 32'd0 : {8'd0, mem_q[rd_ptr_q]};
            AddrStatus:   read_data = status;
            AddrCtrl:     read_data = {31'd0, enable_q};
            AddrFramePix: read_data = {16'd0, frame_pix_reg_q};
            default:      read_data = '0;
        endcase
    end

endmodule

// File: tb/tb_ws2812b_rx.sv
// Self-checking bench for ws2812b_rx: bit-level line stimulus at 50 MHz with a pixel
// scoreboard compared against DATA pops, plus register checks on the boundary cases.
module tb_ws2812b_rx;

    localparam int unsigned Depth = 8;
    localparam logic [7:0]  AData = 8'h00;
    localparam logic [7:0]  AStat = 8'h04;
    localparam logic [7:0]  ACtrl = 8'h08;
    localparam logic [7:0]  AFpix = 8'h0C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic        ws_in = 1'b0;

    ws2812b_rx #(.FIFO_DEPTH(Depth)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .address   (address),
        .write_data(write_data),
        .read_data (read_data),
        .we        (we),
        .re        (re),
        .ws_in     (ws_in)
    );

    always #10 clk = ~clk;

    logic [23:0] exp_q [$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
        @(negedge clk);
        address    = addr;
        write_data = data;
        we         = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] addr, input logic do_re, output logic [31:0] d);
        @(negedge clk);
        address = addr;
        re      = do_re;
        #1 d = read_data;
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [7:0] addr, input logic [31:0] mask,
                             input logic [31:0] exp);
        logic [31:0] d;
        bus_read(addr, 1'b0, d);
        check_eq(tag, d & mask, exp);
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] d;
        logic [31:0] exp;
        exp = (exp_q.size() != 0) ? {8'd0, exp_q.pop_front()} : 32'd0;
        bus_read(AData, 1'b1, d);
        check_eq(tag, d, exp);
    endtask

    task automatic model_push(input logic [23:0] px);
        if (exp_q.size() < Depth) exp_q.push_back(px);
    endtask

    task automatic line_low(input int n);
        ws_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        ws_in = 1'b1;
        repeat (hi) @(negedge clk);
        ws_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // '0' = 0.4us high / 0.85us low, '1' = 0.8us high / 0.45us low
    task automatic send_bit(input logic b);
        if (b) pulse(40, 22);
        else   pulse(20, 42);
    endtask

    task automatic send_bits(input logic [23:0] px, input int nbits);
        for (int i = 23; i > 23 - nbits; i--) send_bit(px[i]);
    endtask

    task automatic send_pixel(input logic [23:0] px, input logic expect_push);
        send_bits(px, 24);
        if (expect_push) model_push(px);
    endtask

    // Last bit is hand-timed so a pop (op=0) or flush (op=1) lands on the push cycle.
    task automatic send_pixel_op(input logic [23:0] px, input int op);
        logic        b;
        logic [31:0] d;
        logic [31:0] exp;
        send_bits(px, 23);
        b = px[0];
        ws_in = 1'b1;
        repeat (b ? 40 : 20) @(negedge clk);
        ws_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (op == 0) begin
            exp     = (exp_q.size() != 0) ? {8'd0, exp_q.pop_front()} : 32'd0;
            address = AData;
            re      = 1'b1;
            #1 d = read_data;
            @(negedge clk);
            re = 1'b0;
            check_eq("pop_on_push_data", d, exp);
            model_push(px);
        end else begin
            address    = ACtrl;
            write_data = 32'h3;
            we         = 1'b1;
            @(negedge clk);
            we = 1'b0;
            exp_q.delete();
        end
        repeat (b ? 19 : 39) @(negedge clk);
    endtask

    localparam int Gap = 1400;

    initial begin
        logic [23:0] px;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reg("rst_status", AStat, 32'hFFFF_FFFF, 32'h1);
        check_reg("rst_data",   AData, 32'hFFFF_FFFF, 32'h0);
        check_reg("rst_ctrl",   ACtrl, 32'hFFFF_FFFF, 32'h0);
        check_reg("rst_fpix",   AFpix, 32'hFFFF_FFFF, 32'h0);

        // 1: one frame, led0 = 0x123456, rest 0
        bus_write(ACtrl, 32'h1);
        check_reg("ctrl_en", ACtrl, 32'hFFFF_FFFF, 32'h1);
        line_low(Gap);
        send_pixel(24'h123456, 1'b1);
        for (int i = 0; i < 7; i++) send_pixel(24'h000000, 1'b1);
        line_low(Gap);
        check_reg("t1_fpix", AFpix, 32'hFFFF_FFFF, 32'd8);
        check_reg("t1_status", AStat, 32'h0000_0F1F, 32'h0000_080A);
        for (int i = 0; i < 8; i++) pop_check("t1_pop");
        check_reg("t1_empty", AStat, 32'h0000_0F03, 32'h1);
        bus_write(AStat, 32'h8);
        check_reg("t1_w1c_done", AStat, 32'h8, 32'h0);

        // 2: two frames without pops -> overflow, keeps first frame
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++) send_pixel(24'($urandom), 1'b1);
            line_low(Gap);
        end
        check_reg("t2_full_ovf", AStat, 32'h0000_0F07, 32'h0000_0806);
        for (int i = 0; i < 8; i++) pop_check("t2_pop");
        check_reg("t2_data_empty", AData, 32'hFFFF_FFFF, 32'h0);
        bus_write(AStat, 32'h1C);

        // 3: partial pixel then reset gap
        send_bits(24'hA5C3F0, 12);
        line_low(1500);
        check_reg("t3_status", AStat, 32'h0000_0F1F, 32'h0000_0011);
        check_reg("t3_fpix", AFpix, 32'hFFFF_FFFF, 32'd8);
        bus_write(AStat, 32'h1C);
        check_reg("t3_w1c_err", AStat, 32'h10, 32'h0);

        // 4: runt and over-long high pulses, then recovery
        line_low(Gap);
        pulse(3, 50);
        check_reg("t4_runt_err", AStat, 32'h10, 32'h10);
        bus_write(AStat, 32'h10);
        line_low(Gap);
        pulse(300, 50);
        check_reg("t4_long_err", AStat, 32'h10, 32'h10);
        bus_write(AStat, 32'h10);
        line_low(Gap);
        send_pixel(24'h00FF81, 1'b1);
        line_low(Gap);
        check_reg("t4_recover_st", AStat, 32'h0000_0F1F, 32'h0000_0108);
        pop_check("t4_pop");
        check_reg("t4_fpix", AFpix, 32'hFFFF_FFFF, 32'd1);
        bus_write(AStat, 32'h1C);

        // 5: pop coincident with push on a full FIFO, then flush coincident with push
        for (int i = 0; i < 8; i++) send_pixel(24'($urandom), 1'b1);
        line_low(Gap);
        check_reg("t5_full", AStat, 32'h0000_0F07, 32'h0000_0802);
        px = 24'($urandom);
        send_pixel_op(px, 0);
        check_reg("t5_pp_count", AStat, 32'h0000_0F07, 32'h0000_0802);
        send_pixel_op(24'($urandom), 1);
        line_low(Gap);
        check_reg("t5_flush", AStat, 32'h0000_0F07, 32'h0000_0001);
        check_reg("t5_ctrl", ACtrl, 32'hFFFF_FFFF, 32'h1);

        // 6: async reset mid-pixel, disable mid-frame, re-enable needs a gap
        send_pixel(24'h0F0F0F, 1'b1);
        line_low(Gap);
        send_bits(24'hFFFFFF, 10);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        check_reg("t6_rst_status", AStat, 32'hFFFF_FFFF, 32'h1);
        check_reg("t6_rst_ctrl",   ACtrl, 32'hFFFF_FFFF, 32'h0);
        check_reg("t6_rst_fpix",   AFpix, 32'hFFFF_FFFF, 32'h0);
        bus_write(ACtrl, 32'h1);
        line_low(Gap);
        send_pixel(24'hC0FFEE, 1'b1);
        send_bits(24'h123456, 10);
        bus_write(ACtrl, 32'h0);
        line_low(Gap);
        check_reg("t6_dis_status", AStat, 32'h0000_0F17, 32'h0000_0100);
        bus_write(ACtrl, 32'h1);
        send_pixel(24'hBADBAD, 1'b0);
        line_low(Gap);
        check_reg("t6_reen_gap", AStat, 32'h0000_0F17, 32'h0000_0100);
        send_pixel(24'h5A5A5A, 1'b1);
        line_low(Gap);
        pop_check("t6_pop0");
        pop_check("t6_pop1");
        check_reg("t6_final", AStat, 32'h0000_0F17, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
